// File: rtl/down_counter_sched_if.sv
// Bundle of request/grant/count signals between the requesters and the shared
// countdown scheduler.
interface down_counter_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int IW   = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] load_val;
    logic               pause;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      count;
    logic               busy;
    logic [IW-1:0]      owner;

    modport master (
        output req, load_val, pause,
        input  grant, done, count, busy, owner
    );

    modport slave (
        input  req, load_val, pause,
        output grant, done, count, busy, owner
    );
endinterface

// File: rtl/down_counter_sched.sv
// One CW-bit countdown timer time-shared among NREQ requesters through a
// round-robin arbiter; the owner gets a one-cycle done pulse at zero.
module down_counter_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int IW   = 2
) (
    input logic                 clk,
    input logic                 rst,
    down_counter_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t          state, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel;
    logic            found;
    logic [CW-1:0]   sel_val;

    // Round-robin pick: scan ptr+1, ptr+2, ... so the last owner comes last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign sel_val = bus.load_val[sel*CW +: CW];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            owner_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            count_q <= count_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (found) state_d = (sel_val == '0) ? DONE : RUN;
            RUN: begin
                if (!bus.req[owner_q])                          state_d = IDLE;
                else if (!bus.pause && count_q == CW'(1))       state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_d = grant_q;
        count_d = count_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_d = sel;
                    grant_d = ONE_HOT0 << sel;
                    count_d = sel_val;
                end
            end
            RUN: begin
                // Abort outranks pause and decrement.
                if (!bus.req[owner_q]) begin
                    grant_d = '0;
                    count_d = '0;
                    ptr_d   = owner_q;
                end else if (!bus.pause && count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = owner_q;
            end
            default: begin
                grant_d = '0;
                count_d = '0;
            end
        endcase
        if (state_d == DONE) done_d = grant_d;
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_down_counter_sched.sv
// Directed bench for down_counter_sched: table of per-edge vectors plus
// hand-written pause, abort and asynchronous-reset sequences.
module tb_down_counter_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] lv;
        logic        pause;
        logic [3:0]  g;
        logic [3:0]  d;
        logic [3:0]  c;
        logic        b;
        logic [1:0]  o;
    } vec_t;

    vec_t tbl[$];

    down_counter_sched_if #(.NREQ(4), .CW(4), .IW(2)) bus ();

    down_counter_sched #(.NREQ(4), .CW(4), .IW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [3:0] d,
                              input logic [3:0] c, input logic b, input logic [1:0] o);
        check({name, ".grant"}, 32'(bus.grant), 32'(g));
        check({name, ".done"},  32'(bus.done),  32'(d));
        check({name, ".count"}, 32'(bus.count), 32'(c));
        check({name, ".busy"},  32'(bus.busy),  32'(b));
        check({name, ".owner"}, 32'(bus.owner), 32'(o));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] req, input logic [15:0] lv, input logic p,
                       input logic [3:0] g, input logic [3:0] d, input logic [3:0] c,
                       input logic b, input logic [1:0] o);
        vec_t v;
        v.rst = r; v.req = req; v.lv = lv; v.pause = p;
        v.g = g; v.d = d; v.c = c; v.b = b; v.o = o;
        tbl.push_back(v);
    endtask

    initial begin
        // Single request of length 3 straight out of reset.
        add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0000, 4'd3, 1, 2'd0);
        add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0000, 4'd2, 1, 2'd0);
        add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0000, 4'd1, 1, 2'd0);
        add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0001, 4'd0, 1, 2'd0);
        add(0, 4'b0000, 16'h0003, 0, 4'b0000, 4'b0000, 4'd0, 0, 2'd0);
        add(0, 4'b0000, 16'h0003, 0, 4'b0000, 4'b0000, 4'd0, 0, 2'd0);
        // Re-reset so round robin starts at index 0.
        add(1, 4'b0000, 16'h0000, 0, 4'b0000, 4'b0000, 4'd0, 0, 2'd0);
        for (int n = 0; n < 5; n++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (n % 4);
            add(0, 4'hF, 16'h1111, 0, oh,      4'b0000, 4'd1, 1, 2'(n % 4));
            add(0, 4'hF, 16'h1111, 0, oh,      oh,      4'd0, 1, 2'(n % 4));
            add(0, 4'hF, 16'h1111, 0, 4'b0000, 4'b0000, 4'd0, 0, 2'(n % 4));
        end
        // Zero length: grant and done on the same edge.
        add(0, 4'b0100, 16'h0000, 0, 4'b0100, 4'b0100, 4'd0, 1, 2'd2);
        add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'b0000, 4'd0, 0, 2'd2);

        bus.req = '0; bus.load_val = '0; bus.pause = 1'b0;
        step();
        step();
        expect_out("reset", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            rst          = tbl[i].rst;
            bus.req      = tbl[i].req;
            bus.load_val = tbl[i].lv;
            bus.pause    = tbl[i].pause;
            step();
            expect_out($sformatf("row%0d", i), tbl[i].g, tbl[i].d, tbl[i].c, tbl[i].b, tbl[i].o);
        end
        rst = 1'b0;

        // Pause: length 4, three held cycles, done at E0+7.
        bus.req = 4'b0001; bus.load_val = 16'h0004; bus.pause = 1'b0;
        step(); expect_out("pause_e0", 4'b0001, 4'b0000, 4'd4, 1'b1, 2'd0);
        step(); expect_out("pause_e1", 4'b0001, 4'b0000, 4'd3, 1'b1, 2'd0);
        bus.pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); expect_out($sformatf("pause_hold%0d", k), 4'b0001, 4'b0000, 4'd3, 1'b1, 2'd0);
        end
        bus.pause = 1'b0;
        step(); expect_out("pause_e5", 4'b0001, 4'b0000, 4'd2, 1'b1, 2'd0);
        step(); expect_out("pause_e6", 4'b0001, 4'b0000, 4'd1, 1'b1, 2'd0);
        step(); expect_out("pause_e7", 4'b0001, 4'b0001, 4'd0, 1'b1, 2'd0);
        bus.req = 4'b0000;
        step(); expect_out("pause_end", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd0);

        // Abort: requester 1 drops at count 6; pending 2 beats 0 next.
        bus.req = 4'b0010; bus.load_val = 16'h00A0;
        step(); expect_out("abort_e0", 4'b0010, 4'b0000, 4'd10, 1'b1, 2'd1);
        for (int k = 1; k <= 4; k++) begin
            step(); expect_out($sformatf("abort_run%0d", k), 4'b0010, 4'b0000, 4'(10 - k), 1'b1, 2'd1);
        end
        bus.req = 4'b0101; bus.load_val = 16'h0507;
        step(); expect_out("abort_drop", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd1);
        step(); expect_out("abort_next", 4'b0100, 4'b0000, 4'd5, 1'b1, 2'd2);
        bus.req = 4'b0000;
        step(); expect_out("abort_two", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd2);

        // Asynchronous reset while count is 5.
        bus.req = 4'b0001; bus.load_val = 16'h0007;
        step(); step(); step();
        expect_out("rst_pre", 4'b0001, 4'b0000, 4'd5, 1'b1, 2'd0);
        #2 rst = 1'b1;
        #1 expect_out("rst_async", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd0);
        step(); expect_out("rst_hold", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd0);
        rst = 1'b0;
        bus.req = 4'b0011; bus.load_val = 16'h0021;
        step(); expect_out("rst_first", 4'b0001, 4'b0000, 4'd1, 1'b1, 2'd0);
        step(); expect_out("rst_done", 4'b0001, 4'b0001, 4'd0, 1'b1, 2'd0);
        bus.req = 4'b0000;
        step(); expect_out("rst_idle", 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/down_counter_sched.md
Name: down_counter_sched

Overview:
Time-shares one 4-bit countdown resource among NREQ requesters. Each requester asks for a countdown of a given length. A round-robin arbiter picks one requester, loads its value, counts down to zero, and signals completion to that requester only. This block sits in front of the down-counter datapath and replaces per-requester counters with one sequenced counter.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 4, counter width in bits; count values 0..2^CW-1
IW, 2, index width, clog2(NREQ); must match NREQ

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset; clears all state immediately
req  input  NREQ  per-requester request; level, held high until its done pulse
load_val  input  NREQ*CW  per-requester countdown length; slice i = bits [i*CW +: CW]; sampled only at grant
pause  input  1  global hold; freezes count while in RUN
grant  output  NREQ  one-hot owner of the counter; all zero when idle
done  output  NREQ  one-cycle completion pulse to the owner
count  output  CW  current counter value
busy  output  1  high in RUN or DONE
owner  output  IW  index of the current or last owner

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, done=0, count=0, busy=0, owner=0.
  - RR pointer=NREQ-1, so index 0 has first priority after reset.
  - Release of rst takes effect at the next clk edge.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - If req==0: stay in IDLE; count holds.
  - Otherwise select the first asserted req scanning ptr+1, ptr+2, ... modulo NREQ. Call this edge E0.
  - At E0: owner<=sel, grant<=onehot(sel), count<=load_val[sel].
  - Next state is RUN if the sampled value V>0, DONE if V=0.
- RUN:
  - Each edge with pause=0: count<=count-1. When count==1, the next state is DONE (count becomes 0).
  - pause=1: count and state hold; grant stays asserted.
  - Abort: if req[owner]==0 at an edge, then count<=0, grant<=0, state<=IDLE, ptr<=owner. No done pulse. Abort has priority over pause and decrement.
- DONE (exactly one cycle):
  - done[owner]=1, count=0, grant still asserted.
  - Next edge: grant<=0, done<=0, ptr<=owner, state<=IDLE.
  - No new grant can occur in the DONE cycle. Minimum gap between grants is one IDLE cycle.
- Timing for value V with no pause:
  - grant is high over [E0, E0+V+1).
  - done is high over [E0+V, E0+V+1).
  - The earliest next grant is at E0+V+2.
  - Each pause cycle extends these windows by one.
- Fairness: after any completion or abort, the previous owner has lowest priority. Any continuously asserted request is granted within NREQ-1 other grants.
- Outputs:
  - busy = (state != IDLE).
  - done and grant are registered outputs, glitch-free.
  - At most one bit of grant and one bit of done is ever high.
- Arithmetic: count never wraps. Decrement is only allowed when count>0. V=2^CW-1 must run the full length.
- Boundary conditions:
  - Requests arriving during RUN/DONE wait in IDLE arbitration; they are not queued internally.
  - A req deasserted by a non-owner has no effect.
  - req[owner] dropping in the DONE cycle still produces the done pulse.
  - rst asserted mid-RUN clears everything in the same cycle; no done pulse.

Test Plan:
- Single request: rst 2 cycles, then req=0001, slice0=3 → grant=0001 at E0; count 3,2,1,0 on E0..E0+3; done=0001 for exactly one cycle at E0+3; grant=0, busy=0 from E0+4.
- Round-robin: req=1111 held, all slices=1 → grant order 0,1,2,3,0. Each grant lasts 2 cycles, each gap is 1 cycle, and done pulses follow the same order.
- Zero length: req=0100, slice2=0 → grant=0100 and done=0100 in the same cycle (E0); count stays 0; IDLE at E0+1.
- Pause: slice0=4, pause=1 for 3 cycles mid-count → count holds its value for 3 cycles; done appears at E0+7.
- Abort: slice1=10, drop req[1] when count=6 → next edge grant=0, count=0, no done. A pending req[2] is granted on the following edge with priority over index 0.
- Reset mid-operation: assert rst asynchronously while count=5 → grant, done, count, busy go to 0 immediately without waiting for a clock. After release, req=0011 grants index 0 first.
